// File: rtl/sme_host.sv
// Host-side sequencer for a string matcher: buffers one job of string/pattern chars,
// streams them to the matcher, then waits for its verdict (or a timeout) and holds the result.
module sme_host #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_char,
    input  logic       job_is_pat,
    input  logic       job_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       res_error,
    output logic [2:0] dbg_state
);
    // Handshakes: a char moves when job_valid && job_ready are high at a rising clk edge;
    // a result moves when res_valid && res_ready are high at a rising clk edge.
    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int SIW = $clog2(STR_MAX);
    localparam int PIW = $clog2(PAT_MAX);

    typedef enum logic [2:0] {LOAD, SEND_STR, SEND_PAT, WAIT, RESULT} state_t;

    state_t        state, state_nxt;
    logic [7:0]    str_buf [STR_MAX];
    logic [7:0]    pat_buf [PAT_MAX];
    logic [SW-1:0] str_len, idx;
    logic [PW-1:0] pat_len;
    logic          seen_pat, err;
    logic [10:0]   wait_cnt;
    logic          accept, str_acc, pat_acc, drop, empty_job;
    logic          last_str, last_pat, timed_out;

    assign dbg_state = state;
    assign res_valid = (state == RESULT);
    assign last_str  = (idx == str_len - SW'(1));
    assign last_pat  = (idx == SW'(pat_len) - SW'(1));
    assign timed_out = (wait_cnt == 11'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
        accept    = 1'b0;
        str_acc   = 1'b0;
        pat_acc   = 1'b0;
        drop      = 1'b0;
        empty_job = 1'b0;
        case (state)
            LOAD: begin
                job_ready = reset;
                accept    = job_valid && reset;
                if (accept) begin
                    // String chars arriving after any pattern char are malformed and dropped.
                    if (job_is_pat) begin
                        if (pat_len < PW'(PAT_MAX)) pat_acc = 1'b1;
                        else                         drop    = 1'b1;
                    end else if (seen_pat || str_len == SW'(STR_MAX)) begin
                        drop = 1'b1;
                    end else begin
                        str_acc = 1'b1;
                    end
                    if (job_last) begin
                        if (str_acc || str_len != '0)      state_nxt = SEND_STR;
                        else if (pat_acc || pat_len != '0) state_nxt = SEND_PAT;
                        else begin
                            state_nxt = RESULT;
                            empty_job = 1'b1;
                        end
                    end
                end
            end
            SEND_STR: begin
                isstring = 1'b1;
                chardata = str_buf[idx[SIW-1:0]];
                if (last_str) state_nxt = (pat_len != '0) ? SEND_PAT : WAIT;
            end
            SEND_PAT: begin
                ispattern = 1'b1;
                chardata  = pat_buf[idx[PIW-1:0]];
                if (last_pat) state_nxt = WAIT;
            end
            WAIT: begin
                if (valid || timed_out) state_nxt = RESULT;
            end
            RESULT: begin
                if (res_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LOAD;
            str_len     <= '0;
            pat_len     <= '0;
            seen_pat    <= 1'b0;
            err         <= 1'b0;
            idx         <= '0;
            wait_cnt    <= '0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b0;
            res_error   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    idx      <= '0;
                    wait_cnt <= '0;
                    if (str_acc) str_len <= str_len + SW'(1);
                    if (pat_acc) pat_len <= pat_len + PW'(1);
                    if (accept && job_is_pat) seen_pat <= 1'b1;
                    if (drop) err <= 1'b1;
                    if (empty_job) begin
                        res_match   <= 1'b0;
                        res_index   <= '0;
                        res_timeout <= 1'b0;
                        res_error   <= 1'b1;
                    end
                end
                SEND_STR: idx <= last_str ? '0 : idx + SW'(1);
                SEND_PAT: idx <= idx + SW'(1);
                WAIT: begin
                    if (valid) begin
                        res_match   <= match;
                        res_index   <= match_index;
                        res_timeout <= 1'b0;
                        res_error   <= err;
                    end else if (timed_out) begin
                        res_match   <= 1'b0;
                        res_index   <= '0;
                        res_timeout <= 1'b1;
                        res_error   <= err;
                    end else begin
                        wait_cnt <= wait_cnt + 11'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        str_len  <= '0;
                        pat_len  <= '0;
                        seen_pat <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Char storage carries no reset; the lengths alone say what is live.
    always_ff @(posedge clk) begin
        if (str_acc) str_buf[str_len[SIW-1:0]] <= job_char;
        if (pat_acc) pat_buf[pat_len[PIW-1:0]] <= job_char;
    end
endmodule

// File: tb/tb_sme_host.sv
// Directed bench for sme_host: a job-level model predicts the char stream and the result,
// a matcher stand-in answers (or stays silent), and one monitor compares every cycle.
module tb_sme_host;
    logic       clk = 1'b0;
    logic       reset;
    logic       job_valid, job_ready, job_is_pat, job_last;
    logic [7:0] job_char, chardata;
    logic       isstring, ispattern;
    logic       valid, match;
    logic [4:0] match_index;
    logic       res_valid, res_ready, res_match, res_timeout, res_error;
    logic [4:0] res_index;
    logic [2:0] dbg_state;

    sme_host dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_char(job_char),
        .job_is_pat(job_is_pat), .job_last(job_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .res_error(res_error),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not happen as required", name);
    endtask

    // Model state: expected stream entries {isstring, ispattern, char}; results {match, index, timeout, error}
    logic [9:0] exp_q[$];
    logic [7:0] res_q[$];
    logic [7:0] job_c[$];
    logic       job_p[$];

    // Matcher stand-in configuration
    logic       resp_en = 1'b0;
    int         resp_delay = 1;
    logic       resp_match = 1'b0;
    logic [4:0] resp_index = 5'd0;
    logic       spur_en = 1'b0;

    // Monitor bookkeeping
    int   cyc = 0;
    int   str_cyc = 0;
    int   pat_cyc = 0;
    int   last_pat_cyc = 0;
    int   res_lat = 0;
    logic prev_stream = 1'b0;
    logic prev_rv = 1'b0;

    // Matcher: answers resp_delay cycles after the last pattern char; optional stray valid while strings stream.
    int   since = 0;
    logic armed = 1'b0;
    always @(negedge clk) begin
        valid = 1'b0;
        match = 1'b0;
        match_index = 5'd0;
        if (!reset) begin
            armed = 1'b0;
        end else if (ispattern) begin
            armed = 1'b1;
            since = 0;
        end else if (armed) begin
            since++;
            if (since == resp_delay) begin
                armed = 1'b0;
                if (resp_en) begin
                    valid = 1'b1;
                    match = resp_match;
                    match_index = resp_index;
                end
            end
        end
        if (spur_en && isstring) begin
            valid = 1'b1;
            match = 1'b0;
            match_index = 5'd17;
        end
    end

    // Single compare process
    always @(negedge clk) begin
        if (!reset) begin
            prev_stream = 1'b0;
            prev_rv = 1'b0;
        end else begin
            cyc++;
            check("stream_exclusive", {31'd0, isstring && ispattern}, 32'd0);
            if (isstring || ispattern) begin
                if (isstring)  str_cyc++;
                if (ispattern) begin
                    pat_cyc++;
                    last_pat_cyc = cyc;
                end
                if (exp_q.size() == 0) fail_now("extra_stream_char");
                else check("stream_char", {22'd0, isstring, ispattern, chardata}, {22'd0, exp_q.pop_front()});
            end else begin
                check("idle_chardata", {24'd0, chardata}, 32'd0);
                if (prev_stream) check("stream_gap", exp_q.size(), 32'd0);
            end
            prev_stream = isstring || ispattern;
            if (res_valid) begin
                if (!prev_rv) res_lat = cyc - last_pat_cyc;
                check("job_ready_in_result", {31'd0, job_ready}, 32'd0);
                if (res_q.size() == 0) fail_now("unexpected_result");
                else begin
                    check("result_fields", {24'd0, res_match, res_index, res_timeout, res_error}, {24'd0, res_q[0]});
                    if (res_ready) res_q.delete(0);
                end
            end
            prev_rv = res_valid;
        end
    end

    task automatic add_chars(input string s, input logic is_pat);
        for (int i = 0; i < s.len(); i++) begin
            job_c.push_back(s[i]);
            job_p.push_back(is_pat);
        end
    endtask

    // Predicts the job outcome from the char list, then offers every char.
    task automatic run_job();
        logic [7:0] sq[$];
        logic [7:0] pq[$];
        logic       seen, err, acc;
        seen = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < job_c.size(); i++) begin
            if (job_p[i]) begin
                seen = 1'b1;
                if (pq.size() < 8) pq.push_back(job_c[i]);
                else               err = 1'b1;
            end else if (seen || sq.size() == 32) begin
                err = 1'b1;
            end else begin
                sq.push_back(job_c[i]);
            end
        end
        foreach (sq[i]) exp_q.push_back({2'b10, sq[i]});
        foreach (pq[i]) exp_q.push_back({2'b01, pq[i]});
        if (resp_en) res_q.push_back({resp_match, resp_index, 1'b0, err});
        else         res_q.push_back({1'b0, 5'd0, 1'b1, err});
        for (int i = 0; i < job_c.size(); i++) begin
            job_valid  = 1'b1;
            job_char   = job_c[i];
            job_is_pat = job_p[i];
            job_last   = (i == job_c.size() - 1);
            acc = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (job_ready) begin
                    acc = 1'b1;
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!acc) fail_now("job_char_accept");
        end
        job_valid = 1'b0;
        job_last  = 1'b0;
        job_c.delete();
        job_p.delete();
    endtask

    task automatic wait_result();
        for (int i = 0; i < 1500; i++) begin
            if (res_valid) break;
            @(posedge clk); #1;
        end
        if (!res_valid) fail_now("result_arrival");
        @(negedge clk); #1;
    endtask

    task automatic finish_result(input int hold);
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("job_ready_after_hs", {31'd0, job_ready}, 32'd1);
        check("res_valid_after_hs", {31'd0, res_valid}, 32'd0);
        check("stream_drained", exp_q.size(), 32'd0);
        check("result_consumed", res_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0;
        logic rv_seen;
        reset = 1'b0;
        job_valid = 1'b0;
        job_char = 8'h00;
        job_is_pat = 1'b0;
        job_last = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_job_ready", {31'd0, job_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_isstring", {31'd0, isstring}, 32'd0);
        check("rst_ispattern", {31'd0, ispattern}, 32'd0);
        check("rst_chardata", {24'd0, chardata}, 32'd0);
        check("rst_res_fields", {24'd0, res_match, res_index, res_timeout, res_error}, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("job_ready_after_rst", {31'd0, job_ready}, 32'd1);

        // "ab cd" + "cd", match at 3, stray valid during the string phase, result held 20 cycles
        resp_en = 1'b1; resp_delay = 3; resp_match = 1'b1; resp_index = 5'd3; spur_en = 1'b1;
        add_chars("ab cd", 1'b0);
        add_chars("cd", 1'b1);
        s0 = str_cyc; p0 = pat_cyc;
        run_job();
        wait_result();
        spur_en = 1'b0;
        check("t1_str_cycles", str_cyc - s0, 32'd5);
        check("t1_pat_cycles", pat_cyc - p0, 32'd2);
        check("t1_result", {24'd0, res_match, res_index, res_timeout, res_error}, {24'd0, 8'b1_00011_0_0});
        check("t1_latency", res_lat, 32'd4);
        finish_result(20);

        // Pattern-only "xy", no match
        resp_en = 1'b1; resp_delay = 1; resp_match = 1'b0; resp_index = 5'd0;
        add_chars("xy", 1'b1);
        s0 = str_cyc; p0 = pat_cyc;
        run_job();
        wait_result();
        check("t2_str_cycles", str_cyc - s0, 32'd0);
        check("t2_pat_cycles", pat_cyc - p0, 32'd2);
        check("t2_res_match", {31'd0, res_match}, 32'd0);
        check("t2_latency", res_lat, 32'd2);
        finish_result(0);

        // Silent matcher: 1023 WAIT cycles, then a timeout result
        resp_en = 1'b0;
        add_chars("hello", 1'b0);
        add_chars("lo", 1'b1);
        run_job();
        wait_result();
        check("t3_timeout", {31'd0, res_timeout}, 32'd1);
        check("t3_latency", res_lat, 32'd1024);
        check("t3_match_index", {26'd0, res_match, res_index}, 32'd0);
        finish_result(2);

        // Ten pattern chars: only eight go out, error flagged
        resp_en = 1'b1; resp_delay = 2; resp_match = 1'b1; resp_index = 5'd9;
        add_chars("0123456789", 1'b1);
        p0 = pat_cyc;
        run_job();
        wait_result();
        check("t4_pat_cycles", pat_cyc - p0, 32'd8);
        check("t4_res_error", {31'd0, res_error}, 32'd1);
        finish_result(1);

        // String char after a pattern char is dropped and flagged
        resp_en = 1'b1; resp_delay = 5; resp_match = 1'b1; resp_index = 5'd2;
        add_chars("abc", 1'b0);
        add_chars("z", 1'b1);
        add_chars("q", 1'b0);
        s0 = str_cyc;
        run_job();
        wait_result();
        check("t5_str_cycles", str_cyc - s0, 32'd3);
        check("t5_res_error", {31'd0, res_error}, 32'd1);
        finish_result(0);

        // 33 string chars: 32 kept, error flagged
        resp_en = 1'b1; resp_delay = 1; resp_match = 1'b0; resp_index = 5'd31;
        add_chars("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefg", 1'b0);
        add_chars("k", 1'b1);
        s0 = str_cyc;
        run_job();
        wait_result();
        check("t6_str_cycles", str_cyc - s0, 32'd32);
        check("t6_res_error", {31'd0, res_error}, 32'd1);
        finish_result(0);

        // Reset while strings stream: job vanishes without a result
        resp_en = 1'b0;
        add_chars("0123456789", 1'b0);
        add_chars("p", 1'b1);
        run_job();
        for (int i = 0; i < 20; i++) begin
            if (isstring) break;
            @(posedge clk); #1;
        end
        if (!isstring) fail_now("t7_stream_start");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t7_isstring_in_rst", {31'd0, isstring}, 32'd0);
        check("t7_res_valid_in_rst", {31'd0, res_valid}, 32'd0);
        exp_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        rv_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (res_valid || isstring || ispattern) rv_seen = 1'b1;
        end
        check("t7_silent_after_abort", {31'd0, rv_seen}, 32'd0);
        check("t7_job_ready", {31'd0, job_ready}, 32'd1);

        // Fresh job after the abort
        resp_en = 1'b1; resp_delay = 2; resp_match = 1'b1; resp_index = 5'd1;
        add_chars("abc", 1'b0);
        add_chars("b", 1'b1);
        s0 = str_cyc; p0 = pat_cyc;
        run_job();
        wait_result();
        check("t8_str_cycles", str_cyc - s0, 32'd3);
        check("t8_pat_cycles", pat_cyc - p0, 32'd1);
        check("t8_result", {24'd0, res_match, res_index, res_timeout, res_error}, {24'd0, 8'b1_00001_0_0});
        finish_result(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sme_host.md
SME_HOST -- requirements
Module: sme_host

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: job_valid  in  1  upstream char offered.
REQ-004 SHALL have ports: job_ready  out  1  block accepts char this cycle.
REQ-005 SHALL have ports: job_char  in  8  ASCII char.
REQ-006 SHALL have ports: job_is_pat  in  1  1 = pattern char, 0 = string char.
REQ-007 SHALL have ports: job_last  in  1  final char of job.
REQ-008 SHALL have ports: chardata  out  8  char to matcher.
REQ-009 SHALL have ports: isstring  out  1  chardata is a string char.
REQ-010 SHALL have ports: ispattern  out  1  chardata is a pattern char.
REQ-011 SHALL have ports: valid  in  1  matcher result valid.
REQ-012 SHALL have ports: match  in  1  matcher found pattern.
REQ-013 SHALL have ports: match_index  in  5  matcher match position.
REQ-014 SHALL have ports: res_valid  out  1  result held for downstream.
REQ-015 SHALL have ports: res_ready  in  1  downstream takes result.
REQ-016 SHALL have ports: res_match, res_index[4:0], res_timeout, res_error  out  result fields.
REQ-017 SHALL have parameters: STR_MAX 32 max string chars; PAT_MAX 8 max pattern chars; TIMEOUT 1023 wait-cycle limit.

Function
REQ-018 SHALL implement FSM states LOAD, SEND_STR, SEND_PAT, WAIT, RESULT; reset state LOAD.
REQ-019 SHALL assert job_ready only in LOAD; a char is accepted when job_valid and job_ready are both 1.
REQ-020 SHALL buffer string chars in order up to STR_MAX and pattern chars up to PAT_MAX; excess chars are dropped and set the job error flag.
REQ-021 SHALL drop any string char accepted after the first pattern char of the same job and set the error flag.
REQ-022 On accepting job_last, SHALL go to SEND_STR if string length > 0, else to SEND_PAT if pattern length > 0, else to RESULT with res_match=0, res_index=0, res_error=1.
REQ-023 In SEND_STR, SHALL drive isstring=1 with one buffered char per cycle for exactly str_len cycles, then enter SEND_PAT with no gap cycle.
REQ-024 In SEND_PAT, SHALL drive ispattern=1 with one char per cycle for exactly pat_len cycles, then enter WAIT.
REQ-025 SHALL never assert isstring and ispattern together; outside SEND states both SHALL be 0 and chardata SHALL be 8'h00.
REQ-026 A pattern-only job SHALL send no string chars, so the matcher reuses its previously loaded string.
REQ-027 SHALL sample valid only in WAIT; on the first valid=1, SHALL capture match and match_index into res_match/res_index and enter RESULT.
REQ-028 SHALL count WAIT cycles in an 11-bit counter; if it reaches TIMEOUT without valid, SHALL enter RESULT with res_timeout=1, res_match=0, res_index=0.
REQ-029 In RESULT, SHALL hold res_valid=1 and all res_* fields stable until res_ready=1; that cycle it SHALL clear res_valid, clear the length and flag registers, and return to LOAD.
REQ-030 valid asserted while not in WAIT SHALL be ignored.

Reset
REQ-031 reset low SHALL asynchronously force state LOAD, all counters and lengths to 0, and all outputs to 0, except job_ready, which is 1 once reset is released.
REQ-032 reset asserted mid-job SHALL abort the job with no result emitted; buffered chars are discarded.

Verification
REQ-033 Job "ab cd"+"cd" (5 string chars, 2 pattern chars), model returns valid, match=1, index=3 -> isstring high for exactly 5 cycles then ispattern for 2; res_match=1, res_index=3, res_timeout=0, res_error=0.
REQ-034 Pattern-only job "xy", model returns match=0 -> isstring never asserted, ispattern for 2 cycles, res_match=0.
REQ-035 Model never asserts valid -> res_valid rises exactly 1023 WAIT cycles after the last ispattern cycle, with res_timeout=1.
REQ-036 10 pattern chars offered -> only 8 sent on ispattern, res_error=1.
REQ-037 res_ready held low for 20 cycles -> res_* stable and job_ready=0 throughout; after the res_ready handshake, job_ready=1 on the next cycle.
REQ-038 reset pulsed low during SEND_STR -> isstring=0 immediately, no res_valid; a fresh job afterwards completes normally.
